execute: RTL and testbench

Execute stage of the RV64IM in-order pipeline: sits between decode and the memory stage and produces the MEM_* pipeline latches the memory stage consumes. Performs single-cycle integer ALU and multiply operations. Performs DIV/DIVU/REM/REMU (and W forms) with a multi-cycle iterative divider that stalls the front end through EX_STALL. Honours back-pressure from the downstream stall.

---
 rtl/exec_pkg.sv | 45 ++++
 rtl/exec_div.sv | 176 +++++++++++++++++
 rtl/execute.sv | 177 +++++++++++++++++
 tb/tb_execute.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the RV64IM execute stage:
//   XLEN        datapath width (64 only)
//   alu_op_t    5-bit ALU operation encoding driven by decode
//   div_state_t iterative divider FSM states
//   sext32      sign-extend a 32-bit value to 64 bits (W-form results)
// -----------------------------------------------------------------------------
package exec_pkg;

    localparam int XLEN = 64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/exec_div.sv
// -----------------------------------------------------------------------------
// exec_div
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the
// iteration and go straight to DONE.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          valid divide op presented (sampled in IDLE only)
//   i_signed         signed divide/remainder
//   i_rem            return remainder instead of quotient
//   i_w              32-bit (W) operation
//   i_a, i_b         dividend, divisor (held stable while o_stall is high)
//   i_ready          downstream can take the result (not MEM_STALL)
//   o_stall          divider is occupying EX (IDLE with start, or BUSY)
//   o_valid          result available (DONE)
//   o_result         final signed/selected/extended result
// -----------------------------------------------------------------------------
module exec_div
    import exec_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic            i_rem,
    input  logic            i_w,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_ready,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_t      r_state;
    div_state_t      w_state_next;
    logic [6:0]      r_count;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] r_b;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_rem;
    logic            r_w;
    logic            r_special;
    logic [XLEN-1:0] r_spec_res;

    // Operands widened to 64 bits according to width and signedness.
    logic [XLEN-1:0] w_a_sx;
    logic [XLEN-1:0] w_b_sx;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_raw;
    logic [XLEN-1:0] w_spec_res;

    assign w_a_sx  = i_w ? (i_signed ? sext32(i_a[31:0]) : {32'b0, i_a[31:0]}) : i_a;
    assign w_b_sx  = i_w ? (i_signed ? sext32(i_b[31:0]) : {32'b0, i_b[31:0]}) : i_b;
    assign w_a_neg = i_signed & w_a_sx[XLEN-1];
    assign w_b_neg = i_signed & w_b_sx[XLEN-1];
    assign w_a_mag = w_a_neg ? (~w_a_sx + 1'b1) : w_a_sx;
    assign w_b_mag = w_b_neg ? (~w_b_sx + 1'b1) : w_b_sx;

    assign w_div0 = (w_b_sx == '0);
    assign w_ovf  = i_signed & (w_b_sx == '1) &
                    (i_w ? (i_a[31:0] == 32'h8000_0000) : (i_a == {1'b1, 63'b0}));
    assign w_special = w_div0 | w_ovf;

    // Special results come straight from the raw dividend; W forms still
    // sign-extend bit 31 like every other W result.
    always_comb begin
        w_spec_raw = '0;
        if (w_div0)
            w_spec_raw = i_rem ? i_a : '1;
        else
            w_spec_raw = i_rem ? '0 : i_a;
        w_spec_res = i_w ? sext32(w_spec_raw[31:0]) : w_spec_raw;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [XLEN:0]   w_rs;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    assign w_rs   = {r_r, r_q[XLEN-1]};
    assign w_ge   = (w_rs >= {1'b0, r_b});
    assign w_diff = w_rs[XLEN-1:0] - r_b;

    // Result assembly in DONE.
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_remv;
    logic [XLEN-1:0] w_sel;

    assign w_quo    = r_q_neg ? (~r_q + 1'b1) : r_q;
    assign w_remv   = r_r_neg ? (~r_r + 1'b1) : r_r;
    assign w_sel    = r_rem ? w_remv : w_quo;
    assign o_result = r_special ? r_spec_res : (r_w ? sext32(w_sel[31:0]) : w_sel);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= DIV_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (i_start) begin
                    o_stall      = 1'b1;
                    w_state_next = w_special ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                o_stall = 1'b1;
                if (r_count == 7'd1)
                    w_state_next = DIV_DONE;
            end
            DIV_DONE: begin
                o_valid = 1'b1;
                if (i_ready)
                    w_state_next = DIV_IDLE;
            end
            default: w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count    <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_b        <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_rem      <= 1'b0;
            r_w        <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        // W dividends sit in the top half so the MSB feed
                        // is always r_q[63]; 32 steps leave the quotient low.
                        r_q        <= i_w ? {w_a_mag[31:0], 32'b0} : w_a_mag;
                        r_r        <= '0;
                        r_b        <= w_b_mag;
                        r_count    <= i_w ? 7'd32 : 7'd64;
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_r_neg    <= w_a_neg;
                        r_rem      <= i_rem;
                        r_w        <= i_w;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                    end
                end
                DIV_BUSY: begin
                    r_q     <= {r_q[XLEN-2:0], w_ge};
                    r_r     <= w_ge ? w_diff : w_rs[XLEN-1:0];
                    r_count <= r_count - 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute
// RV64IM execute stage: operand mux, single-cycle ALU and multiplier, optional
// iterative divider, and the MEM_* pipeline latches.
// Build option: EXECUTE_DIV_EN -- when defined the exec_div divider is built;
// otherwise divide ops complete in one cycle with a zero result.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   EX_V..EX_ECALL      decoded instruction from the decode stage
//   MEM_STALL           memory stage back-pressure; MEM_* latches hold
//   EX_STALL            EX cannot accept a new instruction this cycle
//   MEM_*               registered results toward the memory stage
// -----------------------------------------------------------------------------
module execute
    import exec_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            EX_V,
    input  logic [XLEN-1:0] EX_NPC,
    input  logic [4:0]      EX_OP,
    input  logic            EX_W,
    input  logic [XLEN-1:0] EX_SR1,
    input  logic [XLEN-1:0] EX_SR2,
    input  logic [XLEN-1:0] EX_IMM,
    input  logic            EX_USE_IMM,
    input  logic [XLEN-1:0] EX_CSRFD,
    input  logic [XLEN-1:0] EX_DRID,
    input  logic            EX_ECALL,
    input  logic            MEM_STALL,
    output logic            EX_STALL,
    output logic            MEM_V,
    output logic            MEM_ECALL,
    output logic [XLEN-1:0] MEM_NPC,
    output logic [XLEN-1:0] MEM_CSRFD,
    output logic [XLEN-1:0] MEM_ALU_RESULT,
    output logic [XLEN-1:0] MEM_SR1,
    output logic [XLEN-1:0] MEM_SR2,
    output logic [XLEN-1:0] MEM_RFD,
    output logic [XLEN-1:0] MEM_DRID
);

    // ---------------- operand mux and single-cycle ALU ----------------
    logic [XLEN-1:0]   w_b;
    logic [5:0]        w_shamt;
    logic [XLEN-1:0]   w_srl_src;
    logic [XLEN-1:0]   w_sra_src;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_alu_result;

    assign w_b       = EX_USE_IMM ? EX_IMM : EX_SR2;
    assign w_shamt   = EX_W ? {1'b0, w_b[4:0]} : w_b[5:0];
    // W right shifts see only the low word: zero- or sign-filled above it.
    assign w_srl_src = EX_W ? {32'b0, EX_SR1[31:0]} : EX_SR1;
    assign w_sra_src = EX_W ? sext32(EX_SR1[31:0]) : EX_SR1;

    // One 128-bit multiplier serves all four multiply ops; only the operand
    // extension differs. MUL uses the low half, which is extension-agnostic.
    assign w_mul_a = (alu_op_t'(EX_OP) == ALU_MULHU) ? {64'b0, EX_SR1}
                                                     : {{64{EX_SR1[XLEN-1]}}, EX_SR1};
    assign w_mul_b = (alu_op_t'(EX_OP) == ALU_MULH)  ? {{64{w_b[XLEN-1]}}, w_b}
                                                     : {64'b0, w_b};
    assign w_prod  = w_mul_a * w_mul_b;

    always_comb begin
        w_raw = '0;
        case (alu_op_t'(EX_OP))
            ALU_ADD:    w_raw = EX_SR1 + w_b;
            ALU_SUB:    w_raw = EX_SR1 - w_b;
            ALU_SLL:    w_raw = EX_SR1 << w_shamt;
            ALU_SLT:    w_raw = {63'b0, $signed(EX_SR1) < $signed(w_b)};
            ALU_SLTU:   w_raw = {63'b0, EX_SR1 < w_b};
            ALU_XOR:    w_raw = EX_SR1 ^ w_b;
            ALU_SRL:    w_raw = w_srl_src >> w_shamt;
            ALU_SRA:    w_raw = $signed(w_sra_src) >>> w_shamt;
            ALU_OR:     w_raw = EX_SR1 | w_b;
            ALU_AND:    w_raw = EX_SR1 & w_b;
            ALU_PASSB:  w_raw = w_b;
            ALU_MUL:    w_raw = w_prod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  w_raw = w_prod[2*XLEN-1:XLEN];
            default:    w_raw = '0;
        endcase
        w_alu_result = EX_W ? sext32(w_raw[31:0]) : w_raw;
    end

    // ---------------- divider ----------------
    logic            w_div_take;
    logic            w_div_stall;
    logic            w_div_valid;
    logic [XLEN-1:0] w_div_result;

`ifdef EXECUTE_DIV_EN
    logic w_div_op;
    assign w_div_op = (alu_op_t'(EX_OP) == ALU_DIV)  | (alu_op_t'(EX_OP) == ALU_DIVU) |
                      (alu_op_t'(EX_OP) == ALU_REM)  | (alu_op_t'(EX_OP) == ALU_REMU);
    // Divide ops never take the single-cycle path; they only reach MEM
    // through the divider's DONE state.
    assign w_div_take = w_div_op;

    exec_div u_div (
        .i_clk    (CLK),
        .i_reset  (RESET),
        .i_start  (EX_V & w_div_op),
        .i_signed ((alu_op_t'(EX_OP) == ALU_DIV) | (alu_op_t'(EX_OP) == ALU_REM)),
        .i_rem    ((alu_op_t'(EX_OP) == ALU_REM) | (alu_op_t'(EX_OP) == ALU_REMU)),
        .i_w      (EX_W),
        .i_a      (EX_SR1),
        .i_b      (w_b),
        .i_ready  (~MEM_STALL),
        .o_stall  (w_div_stall),
        .o_valid  (w_div_valid),
        .o_result (w_div_result)
    );
`else
    assign w_div_take   = 1'b0;
    assign w_div_stall  = 1'b0;
    assign w_div_valid  = 1'b0;
    assign w_div_result = '0;
`endif

    assign EX_STALL = MEM_STALL | w_div_stall;

    // ---------------- MEM_* latches ----------------
    logic            r_mem_v;
    logic            r_mem_ecall;
    logic [XLEN-1:0] r_mem_npc;
    logic [XLEN-1:0] r_mem_csrfd;
    logic [XLEN-1:0] r_mem_alu;
    logic [XLEN-1:0] r_mem_sr1;
    logic [XLEN-1:0] r_mem_sr2;
    logic [XLEN-1:0] r_mem_drid;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mem_v     <= 1'b0;
            r_mem_ecall <= 1'b0;
            r_mem_npc   <= '0;
            r_mem_csrfd <= '0;
            r_mem_alu   <= '0;
            r_mem_sr1   <= '0;
            r_mem_sr2   <= '0;
            r_mem_drid  <= '0;
        end else if (!MEM_STALL) begin
            // Pass-through fields are always captured; the inputs of a
            // divide are still held by upstream when its result is taken.
            r_mem_ecall <= EX_ECALL;
            r_mem_npc   <= EX_NPC;
            r_mem_csrfd <= EX_CSRFD;
            r_mem_sr1   <= EX_SR1;
            r_mem_sr2   <= EX_SR2;
            r_mem_drid  <= EX_DRID;
            if (w_div_valid) begin
                r_mem_v   <= 1'b1;
                r_mem_alu <= w_div_result;
            end else begin
                r_mem_v   <= EX_V & ~w_div_take;
                r_mem_alu <= w_alu_result;
            end
        end
    end

    assign MEM_V          = r_mem_v;
    assign MEM_ECALL      = r_mem_ecall;
    assign MEM_NPC        = r_mem_npc;
    assign MEM_CSRFD      = r_mem_csrfd;
    assign MEM_ALU_RESULT = r_mem_alu;
    assign MEM_SR1        = r_mem_sr1;
    assign MEM_SR2        = r_mem_sr2;
    assign MEM_RFD        = r_mem_sr2;
    assign MEM_DRID       = r_mem_drid;

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute
// Directed bench for the execute stage. Divider timing/result steps are built
// when EXECUTE_DIV_EN is defined; otherwise the single-cycle zero-result
// behaviour of divide ops is exercised instead.
// -----------------------------------------------------------------------------
module tb_execute;
    import exec_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EX_V;
    logic [63:0] EX_NPC;
    logic [4:0]  EX_OP;
    logic        EX_W;
    logic [63:0] EX_SR1;
    logic [63:0] EX_SR2;
    logic [63:0] EX_IMM;
    logic        EX_USE_IMM;
    logic [63:0] EX_CSRFD;
    logic [63:0] EX_DRID;
    logic        EX_ECALL;
    logic        MEM_STALL;
    logic        EX_STALL;
    logic        MEM_V;
    logic        MEM_ECALL;
    logic [63:0] MEM_NPC;
    logic [63:0] MEM_CSRFD;
    logic [63:0] MEM_ALU_RESULT;
    logic [63:0] MEM_SR1;
    logic [63:0] MEM_SR2;
    logic [63:0] MEM_RFD;
    logic [63:0] MEM_DRID;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_npc;
    logic [63:0] exp_drid;

    always #5 CLK = ~CLK;

    execute dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .EX_V           (EX_V),
        .EX_NPC         (EX_NPC),
        .EX_OP          (EX_OP),
        .EX_W           (EX_W),
        .EX_SR1         (EX_SR1),
        .EX_SR2         (EX_SR2),
        .EX_IMM         (EX_IMM),
        .EX_USE_IMM     (EX_USE_IMM),
        .EX_CSRFD       (EX_CSRFD),
        .EX_DRID        (EX_DRID),
        .EX_ECALL       (EX_ECALL),
        .MEM_STALL      (MEM_STALL),
        .EX_STALL       (EX_STALL),
        .MEM_V          (MEM_V),
        .MEM_ECALL      (MEM_ECALL),
        .MEM_NPC        (MEM_NPC),
        .MEM_CSRFD      (MEM_CSRFD),
        .MEM_ALU_RESULT (MEM_ALU_RESULT),
        .MEM_SR1        (MEM_SR1),
        .MEM_SR2        (MEM_SR2),
        .MEM_RFD        (MEM_RFD),
        .MEM_DRID       (MEM_DRID)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input alu_op_t op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic ui);
        EX_V       = v;
        EX_OP      = op;
        EX_W       = w;
        EX_SR1     = a;
        EX_SR2     = b;
        EX_IMM     = imm;
        EX_USE_IMM = ui;
        EX_NPC     = EX_NPC + 64'd4;
        EX_CSRFD   = {32'hC5C5_0000, EX_NPC[31:0]};
        EX_DRID    = {59'b0, EX_NPC[6:2]};
        exp_npc    = EX_NPC;
        exp_drid   = EX_DRID;
        $display("txn v=%0d op=%0d w=%0d a=0x%h b=0x%h imm=0x%h use_imm=%0d",
                 v, op, w, a, b, imm, ui);
    endtask

    // Counts EX_STALL-high cycles of a divide driven just before the call,
    // then checks the result latched on the edge after DONE.
    task automatic run_div(input string tag, input int exp_stall, input logic [63:0] exp_res);
        int n;
        n = 0;
        #1;
        while (EX_STALL && n < 200) begin
            n++;
            tick();
        end
        chk({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
        chk({tag, " pre_mem_v"}, {63'b0, MEM_V}, 64'd0);
        tick();
        chk({tag, " mem_v"}, {63'b0, MEM_V}, 64'd1);
        chk({tag, " result"}, MEM_ALU_RESULT, exp_res);
    endtask

    initial begin
        RESET      = 1'b1;
        EX_V       = 1'b0;
        EX_NPC     = 64'h1000;
        EX_OP      = 5'd0;
        EX_W       = 1'b0;
        EX_SR1     = '0;
        EX_SR2     = '0;
        EX_IMM     = '0;
        EX_USE_IMM = 1'b0;
        EX_CSRFD   = '0;
        EX_DRID    = '0;
        EX_ECALL   = 1'b0;
        MEM_STALL  = 1'b0;
        exp_npc    = '0;
        exp_drid   = '0;

        tick();
        tick();
        chk("reset mem_v", {63'b0, MEM_V}, 64'd0);
        chk("reset ex_stall", {63'b0, EX_STALL}, 64'd0);
        chk("reset alu", MEM_ALU_RESULT, 64'd0);
        chk("reset npc", MEM_NPC, 64'd0);
        RESET = 1'b0;

        // ADD 5 + 7
        drive(1'b1, ALU_ADD, 1'b0, 64'd5, 64'd7, 64'd0, 1'b0);
        EX_ECALL = 1'b1;
        tick();
        chk("add mem_v", {63'b0, MEM_V}, 64'd1);
        chk("add result", MEM_ALU_RESULT, 64'd12);
        chk("add npc", MEM_NPC, exp_npc);
        chk("add rfd", MEM_RFD, 64'd7);
        chk("add sr1", MEM_SR1, 64'd5);
        chk("add drid", MEM_DRID, exp_drid);
        chk("add ecall", {63'b0, MEM_ECALL}, 64'd1);
        EX_ECALL = 1'b0;

        drive(1'b1, ALU_SUB, 1'b1, 64'd0, 64'd1, 64'd0, 1'b0);
        tick();
        chk("subw result", MEM_ALU_RESULT, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1'b1, ALU_SLL, 1'b0, 64'd1, 64'd99, 64'd36, 1'b1);
        tick();
        chk("sll imm 36", MEM_ALU_RESULT, 64'h0000_0010_0000_0000);

        drive(1'b1, ALU_SLL, 1'b1, 64'd1, 64'd36, 64'd0, 1'b0);
        tick();
        chk("sllw shamt masks to 4", MEM_ALU_RESULT, 64'd16);

        drive(1'b1, ALU_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'd0, 1'b0);
        tick();
        chk("sraw", MEM_ALU_RESULT, 64'hFFFF_FFFF_F800_0000);

        drive(1'b1, ALU_SRL, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0);
        tick();
        chk("srl 63", MEM_ALU_RESULT, 64'd1);

        drive(1'b1, ALU_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
        tick();
        chk("slt", MEM_ALU_RESULT, 64'd1);

        drive(1'b1, ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
        tick();
        chk("sltu", MEM_ALU_RESULT, 64'd0);

        drive(1'b1, ALU_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
        tick();
        chk("mul", MEM_ALU_RESULT, 64'hFFFF_FFFF_FFFF_FFF4);

        drive(1'b1, ALU_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        tick();
        chk("mulh", MEM_ALU_RESULT, 64'd0);

        drive(1'b1, ALU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0);
        tick();
        chk("mulhu", MEM_ALU_RESULT, 64'd1);

        drive(1'b1, ALU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0);
        tick();
        chk("mulhsu", MEM_ALU_RESULT, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1'b1, ALU_PASSB, 1'b0, 64'd1, 64'd2, 64'hABCD, 1'b1);
        tick();
        chk("passb imm", MEM_ALU_RESULT, 64'hABCD);

        drive(1'b0, ALU_ADD, 1'b0, 64'd1, 64'd1, 64'd0, 1'b0);
        tick();
        chk("bubble mem_v", {63'b0, MEM_V}, 64'd0);

        // MEM_STALL holds a completed single-cycle result.
        drive(1'b1, ALU_ADD, 1'b0, 64'd1, 64'd1, 64'd0, 1'b0);
        tick();
        chk("pre-stall add", MEM_ALU_RESULT, 64'd2);
        MEM_STALL = 1'b1;
        drive(1'b1, ALU_ADD, 1'b0, 64'd10, 64'd20, 64'd0, 1'b0);
        #1;
        chk("stall ex_stall", {63'b0, EX_STALL}, 64'd1);
        tick();
        chk("stall hold result", MEM_ALU_RESULT, 64'd2);
        chk("stall hold sr1", MEM_SR1, 64'd1);
        MEM_STALL = 1'b0;
        tick();
        chk("post-stall add", MEM_ALU_RESULT, 64'd30);

`ifdef EXECUTE_DIV_EN
        drive(1'b1, ALU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
        run_div("div -7/2", 65, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div npc", MEM_NPC, exp_npc);

        drive(1'b1, ALU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
        run_div("rem -7/2", 65, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1'b1, ALU_DIVU, 1'b0, 64'd123, 64'd0, 64'd0, 1'b0);
        run_div("divu x/0", 1, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1'b1, ALU_REMU, 1'b0, 64'd123, 64'd0, 64'd0, 1'b0);
        run_div("remu x/0", 1, 64'd123);

        drive(1'b1, ALU_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_div("divw ovf", 1, 64'hFFFF_FFFF_8000_0000);

        drive(1'b1, ALU_DIVU, 1'b1, 64'd100, 64'd7, 64'd0, 1'b0);
        run_div("divuw 100/7", 33, 64'd14);

        drive(1'b1, ALU_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
        run_div("remw -7/2", 33, 64'hFFFF_FFFF_FFFF_FFFF);

        // MEM_STALL for three cycles while DONE.
        begin
            int n;
            drive(1'b1, ALU_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0);
            n = 0;
            #1;
            while (EX_STALL && n < 200) begin
                n++;
                tick();
            end
            chk("dstall reach done", 64'(n), 64'd65);
            MEM_STALL = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("dstall hold mem_v", {63'b0, MEM_V}, 64'd0);
                chk("dstall ex_stall", {63'b0, EX_STALL}, 64'd1);
            end
            MEM_STALL = 1'b0;
            #1;
            chk("dstall release ex_stall", {63'b0, EX_STALL}, 64'd0);
            tick();
            chk("dstall result mem_v", {63'b0, MEM_V}, 64'd1);
            chk("dstall result", MEM_ALU_RESULT, 64'hFFFF_FFFF_FFFF_FFDF);
            drive(1'b0, ALU_ADD, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
            tick();
            chk("dstall once", {63'b0, MEM_V}, 64'd0);
        end
`else
        drive(1'b1, ALU_DIV, 1'b0, 64'd7, 64'd2, 64'd0, 1'b0);
        #1;
        chk("nodiv ex_stall", {63'b0, EX_STALL}, 64'd0);
        tick();
        chk("nodiv mem_v", {63'b0, MEM_V}, 64'd1);
        chk("nodiv result", MEM_ALU_RESULT, 64'd0);
        drive(1'b1, ALU_REMU, 1'b1, 64'd9, 64'd4, 64'd0, 1'b0);
        tick();
        chk("nodiv remuw result", MEM_ALU_RESULT, 64'd0);
`endif

        // Reset pulsed while a divide is in flight.
        drive(1'b1, ALU_DIV, 1'b0, 64'd1000, 64'd3, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            tick();
        RESET = 1'b1;
        drive(1'b0, ALU_ADD, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        tick();
        RESET = 1'b0;
        chk("midreset mem_v", {63'b0, MEM_V}, 64'd0);
        chk("midreset ex_stall", {63'b0, EX_STALL}, 64'd0);
        chk("midreset alu", MEM_ALU_RESULT, 64'd0);
        drive(1'b1, ALU_ADD, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0);
        tick();
        chk("post-reset add mem_v", {63'b0, MEM_V}, 64'd1);
        chk("post-reset add", MEM_ALU_RESULT, 64'd3);
        drive(1'b0, ALU_ADD, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
        tick();
        chk("post-reset no repeat", {63'b0, MEM_V}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
